// File: rtl/lector_de_memoria.sv
// lector_de_memoria: reads len words from a synchronous memory starting at base and hands them downstream one at a time
// Ports: CLK/RESET (async, active high)/CE clock enable; sel+base+len start a request;
// mem_en/mem_addr/mem_data talk to the memory; dout/dout_valid/dout_ready form the output handshake;
// busy is high outside IDLE, done pulses once when a request completes.
module lector_de_memoria #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 11
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              CE,
  input  logic              sel,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W-1:0] len,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              dout_ready,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  output logic              busy,
  output logic              done
);
  typedef enum logic [2:0] {IDLE, READ, LOAD, OUT, DONE} state_t;
  state_t state, state_n;
  logic [ADDR_W-1:0] addr, addr_n, cnt, cnt_n;
  logic [DATA_W-1:0] dout_n;
  logic valid_n;
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) begin
      state      <= IDLE;
      addr       <= '0;
      cnt        <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
    end else if (CE) begin
      state      <= state_n;
      addr       <= addr_n;
      cnt        <= cnt_n;
      dout       <= dout_n;
      dout_valid <= valid_n;
    end
  always_comb begin
    state_n = state;
    addr_n  = addr;
    cnt_n   = cnt;
    dout_n  = dout;
    valid_n = dout_valid;
    case (state)
      IDLE: if (sel) begin
        state_n = (len != '0) ? READ : DONE;
        addr_n  = (len != '0) ? base : addr;
        cnt_n   = (len != '0) ? len : cnt;
      end
      READ: state_n = LOAD;
      LOAD: begin
        dout_n  = mem_data;
        valid_n = 1'b1;
        state_n = OUT;
      end
      OUT: if (dout_ready) begin
        valid_n = 1'b0;
        cnt_n   = cnt - 1'b1;
        state_n = (cnt == ADDR_W'(1)) ? DONE : READ;
        addr_n  = (cnt == ADDR_W'(1)) ? addr : addr + 1'b1;
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  // The strobe is gated by CE so a frozen READ re-issues exactly one access when CE returns.
  assign mem_en   = CE && (state == READ);
  assign mem_addr = addr;
  assign busy     = (state != IDLE);
  assign done     = (state == DONE);
endmodule
